// File: rtl/pe_accum_part_sum_fsm.sv
// ----------------------------------------------------------------------------
// pe_accum_part_sum_fsm
//
// Accumulates partial sums received from the network interface into a
// per-rank register file. Each round expects rank_no * contrib_no beats. A
// beat is read-modify-written over two cycles:
//   cycle t   : accept beat, issue register-file read
//   cycle t+1 : add beat data to the base value and write the result back
// The first contribution to a rank uses a base of zero. This is tracked by a
// per-rank "seen" vector, so the register file needs no clearing between
// rounds. Back-to-back beats to the same rank take their base from the
// previous cycle's write, because that write is not yet readable.
//
// Optional feature (define the macro to enable):
//   PART_SUM_SAT_EN : saturate the addition to the signed DATA_W range
//                     (default build wraps modulo 2^DATA_W)
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   PE_IDX              : PE index, used only for identification in simulation
//   start               : pulse that opens a round (ignored while accumulating)
//   rank_no, contrib_no : round geometry, sampled on start
//   recv_rdy            : ready to accept a beat
//   part_sum_recv_*     : incoming beat (valid, rank index, data)
//   acc_read_*          : register-file read port (data valid one cycle later)
//   acc_write_*         : register-file write port
//   fin_rx_part_sum     : one-cycle pulse when the round completes
//   addr_err            : sticky flag for a beat with rank index >= rank_no
// ----------------------------------------------------------------------------
module pe_accum_part_sum_fsm #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RANK_W = 5,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        PE_IDX,
    input  logic              start,
    input  logic [RANK_W-1:0] rank_no,
    input  logic [CNT_W-1:0]  contrib_no,
    output logic              recv_rdy,
    input  logic              part_sum_recv_en,
    input  logic [RANK_W-1:0] part_sum_recv_addr,
    input  logic [DATA_W-1:0] part_sum_recv_data,
    output logic              acc_read_en,
    output logic [RANK_W-1:0] acc_read_addr,
    input  logic [DATA_W-1:0] acc_read_data,
    output logic              acc_write_en,
    output logic [RANK_W-1:0] acc_write_addr,
    output logic [DATA_W-1:0] acc_write_data,
    output logic              fin_rx_part_sum,
    output logic              addr_err
);

    localparam int unsigned BC_W  = RANK_W + CNT_W;
    localparam int unsigned NRANK = 2 ** RANK_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [BC_W-1:0] BC_ONE = 1;

    logic [0:0]        r_state;
    logic [RANK_W-1:0] r_rank_no;
    logic [CNT_W-1:0]  r_contrib_no;
    logic [BC_W-1:0]   r_beat_cnt;
    logic [NRANK-1:0]  r_seen;
    logic              r_addr_err;
    logic              r_zero_fin;

    // Stage 1: beat accepted in the previous cycle
    logic              r_s1_valid;   // in-range beat, write pending
    logic              r_s1_last;    // last expected beat of the round
    logic [RANK_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_data;

    // Previous cycle's write, used as base for back-to-back same-rank beats
    logic              r_prev_wen;
    logic [RANK_W-1:0] r_prev_waddr;
    logic [DATA_W-1:0] r_prev_wdata;

    logic [BC_W-1:0]   w_total;
    logic              w_accept;
    logic              w_in_range;
    logic              w_last;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_sum;
    logic              w_unused_pe_idx;

    assign w_unused_pe_idx = ^PE_IDX;

    assign w_total    = BC_W'(r_rank_no) * BC_W'(r_contrib_no);
    assign recv_rdy   = (r_state == S_ACCUM) && (r_beat_cnt < w_total);
    assign w_accept   = part_sum_recv_en && recv_rdy;
    assign w_in_range = part_sum_recv_addr < r_rank_no;
    assign w_last     = w_accept && ((r_beat_cnt + BC_ONE) == w_total);

    assign acc_read_en   = w_accept && w_in_range;
    assign acc_read_addr = acc_read_en ? part_sum_recv_addr : '0;

    always_comb begin
        w_base = '0;
        if (r_seen[r_s1_addr]) begin
            if (r_prev_wen && (r_prev_waddr == r_s1_addr)) begin
                w_base = r_prev_wdata;
            end else begin
                w_base = acc_read_data;
            end
        end
    end

`ifdef PART_SUM_SAT_EN
    logic [DATA_W:0] w_sum_ext;

    always_comb begin
        w_sum_ext = {w_base[DATA_W-1], w_base} + {r_s1_data[DATA_W-1], r_s1_data};
        // Overflow when the extended sign disagrees with the result sign
        if (w_sum_ext[DATA_W] != w_sum_ext[DATA_W-1]) begin
            w_sum = w_sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            w_sum = w_sum_ext[DATA_W-1:0];
        end
    end
`else
    assign w_sum = w_base + r_s1_data;
`endif

    assign acc_write_en    = r_s1_valid;
    assign acc_write_addr  = r_s1_valid ? r_s1_addr : '0;
    assign acc_write_data  = r_s1_valid ? w_sum : '0;
    assign fin_rx_part_sum = r_s1_last || r_zero_fin;
    assign addr_err        = r_addr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rank_no    <= '0;
            r_contrib_no <= '0;
            r_beat_cnt   <= '0;
            r_seen       <= '0;
            r_addr_err   <= 1'b0;
            r_zero_fin   <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_data    <= '0;
            r_prev_wen   <= 1'b0;
            r_prev_waddr <= '0;
            r_prev_wdata <= '0;
        end else begin
            r_zero_fin   <= 1'b0;
            r_s1_valid   <= acc_read_en;
            r_s1_last    <= w_last;
            r_prev_wen   <= acc_write_en;
            r_prev_waddr <= acc_write_addr;
            r_prev_wdata <= acc_write_data;

            if (w_accept) begin
                r_s1_addr  <= part_sum_recv_addr;
                r_s1_data  <= part_sum_recv_data;
                r_beat_cnt <= r_beat_cnt + BC_ONE;
                if (!w_in_range) begin
                    r_addr_err <= 1'b1;
                end
            end

            if (r_s1_valid) begin
                r_seen[r_s1_addr] <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rank_no    <= rank_no;
                        r_contrib_no <= contrib_no;
                        r_beat_cnt   <= '0;
                        r_seen       <= '0;
                        r_addr_err   <= 1'b0;
                        // An empty round completes immediately without leaving IDLE
                        if ((rank_no == '0) || (contrib_no == '0)) begin
                            r_zero_fin <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (r_s1_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_accum_part_sum_fsm.sv
module tb_pe_accum_part_sum_fsm;

    localparam int DW = 16;
    localparam int RW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    pe_idx = 6'd3;
    logic          start;
    logic [RW-1:0] rank_no;
    logic [CW-1:0] contrib_no;
    logic          recv_rdy;
    logic          en;
    logic [RW-1:0] addr;
    logic [DW-1:0] data;
    logic          acc_read_en;
    logic [RW-1:0] acc_read_addr;
    logic [DW-1:0] acc_read_data;
    logic          acc_write_en;
    logic [RW-1:0] acc_write_addr;
    logic [DW-1:0] acc_write_data;
    logic          fin;
    logic          addr_err;

    pe_accum_part_sum_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .PE_IDX            (pe_idx),
        .start             (start),
        .rank_no           (rank_no),
        .contrib_no        (contrib_no),
        .recv_rdy          (recv_rdy),
        .part_sum_recv_en  (en),
        .part_sum_recv_addr(addr),
        .part_sum_recv_data(data),
        .acc_read_en       (acc_read_en),
        .acc_read_addr     (acc_read_addr),
        .acc_read_data     (acc_read_data),
        .acc_write_en      (acc_write_en),
        .acc_write_addr    (acc_write_addr),
        .acc_write_data    (acc_write_data),
        .fin_rx_part_sum   (fin),
        .addr_err          (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: read data one cycle after the read, writes visible next cycle
    logic [DW-1:0] mem [32];
    logic [DW-1:0] rd_q;
    logic          scramble;
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 32; i++) mem[i] <= DW'($urandom);
        end else if (acc_write_en) begin
            mem[acc_write_addr] <= acc_write_data;
        end
        if (acc_read_en) rd_q <= mem[acc_read_addr];
    end
    assign acc_read_data = rd_q;

    // Observed writes and fin pulses
    logic [RW-1:0] ow_addr[$];
    logic [DW-1:0] ow_data[$];
    int            fin_q[$];
    always @(negedge clk) begin
        if (acc_write_en) begin
            ow_addr.push_back(acc_write_addr);
            ow_data.push_back(acc_write_data);
        end
        if (fin) fin_q.push_back(cyc);
    end

    int n_vec = 0;
    int n_bad = 0;

    // Round stimulus and observations
    logic [RW-1:0] b_addr[$];
    logic [DW-1:0] b_data[$];
    int            start_cyc, first_acc, last_acc, n_reads;
    logic          timeout, junk_rdy, err_after_start;

    // Reference results
    logic [RW-1:0] e_addr[$];
    logic [DW-1:0] e_data[$];
    int            e_reads;
    logic          e_err;

    task automatic build_expected(input int rank);
        int accv[32];
        int s;
        logic signed [DW-1:0] t16;
        e_addr.delete();
        e_data.delete();
        e_reads = 0;
        e_err = 1'b0;
        for (int k = 0; k < 32; k++) accv[k] = 0;
        foreach (b_addr[k]) begin
            if (int'(b_addr[k]) >= rank) begin
                e_err = 1'b1;
            end else begin
                s = accv[b_addr[k]] + int'($signed(b_data[k]));
`ifdef PART_SUM_SAT_EN
                if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
                if (s < -(1 << (DW - 1))) s = -(1 << (DW - 1));
`else
                t16 = DW'(s);
                s = int'(t16);
`endif
                accv[b_addr[k]] = s;
                e_addr.push_back(b_addr[k]);
                e_data.push_back(DW'(s));
                e_reads++;
            end
        end
    endtask

    task automatic run_round(input int rank, input int contrib, input int gap);
        int i;
        int guard;
        int nb;
        nb = b_addr.size();
        ow_addr.delete();
        ow_data.delete();
        fin_q.delete();
        n_reads = 0;
        junk_rdy = 1'b0;
        first_acc = -1;
        last_acc = -1;
        @(negedge clk);
        scramble = 1'b1;
        en = 1'b1;
        addr = RW'($urandom);
        data = DW'($urandom);
        #1 if (recv_rdy) junk_rdy = 1'b1;
        @(negedge clk);
        scramble = 1'b0;
        start = 1'b1;
        rank_no = RW'(rank);
        contrib_no = CW'(contrib);
        start_cyc = cyc;
        #1 if (recv_rdy) junk_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en = 1'b0;
        err_after_start = addr_err;
        i = 0;
        guard = 0;
        while (i < nb && guard < 2000) begin
            if (int'($urandom_range(99)) < gap) begin
                en = 1'b0;
            end else begin
                en = 1'b1;
                addr = b_addr[i];
                data = b_data[i];
            end
            #1;
            if (acc_read_en) n_reads++;
            if (en && recv_rdy) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                i++;
            end
            @(negedge clk);
            guard++;
        end
        timeout = (i < nb);
        repeat (3) begin
            en = 1'b1;
            addr = RW'($urandom);
            data = DW'($urandom);
            #1;
            if (recv_rdy) junk_rdy = 1'b1;
            if (acc_read_en) n_reads++;
            @(negedge clk);
        end
        en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({recv_rdy, acc_read_en, acc_write_en, fin, addr_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {recv_rdy, acc_read_en, acc_write_en, fin, addr_err});
        end
        n_vec++;
        if ({acc_read_addr, acc_write_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_addr: got %h want 0", {acc_read_addr, acc_write_addr});
        end
        n_vec++;
        if (acc_write_data !== '0) begin
            n_bad++;
            $display("FAIL reset_wdata: got %h want 0", acc_write_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_round;
        b_addr.delete();
        b_data.delete();
        for (int k = 0; k < 4; k++) begin
            b_addr.push_back(RW'(k));
            b_data.push_back(DW'(k + 1));
        end
        for (int k = 0; k < 4; k++) begin
            b_addr.push_back(RW'(k));
            b_data.push_back(DW'(10));
        end
        build_expected(4);
        run_round(4, 2, 0);
        n_vec++;
        if (timeout || ow_addr.size() != e_addr.size()) begin
            n_bad++;
            $display("FAIL basic_count: got %0d writes (timeout %b) want %0d",
                     ow_addr.size(), timeout, e_addr.size());
        end
        for (int k = 0; k < e_addr.size() && k < ow_addr.size(); k++) begin
            n_vec++;
            if ({ow_addr[k], ow_data[k]} !== {e_addr[k], e_data[k]}) begin
                n_bad++;
                $display("FAIL basic_write%0d: got a%0d d%0d want a%0d d%0d", k,
                         ow_addr[k], ow_data[k], e_addr[k], e_data[k]);
            end
        end
        n_vec++;
        if (fin_q.size() != 1 || fin_q[0] != last_acc + 1) begin
            n_bad++;
            $display("FAIL basic_fin: got %0d pulses first at %0d want 1 at %0d",
                     fin_q.size(), (fin_q.size() > 0) ? fin_q[0] : -1, last_acc + 1);
        end
        n_vec++;
        if (n_reads != e_reads || junk_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_reads: got %0d reads rdy_leak %b want %0d reads rdy_leak 0",
                     n_reads, junk_rdy, e_reads);
        end
    endtask

    task automatic test_forwarding;
        logic [DW-1:0] want[3];
        want[0] = 16'd5;
        want[1] = 16'd11;
        want[2] = 16'd18;
        b_addr.delete();
        b_data.delete();
        for (int k = 0; k < 3; k++) begin
            b_addr.push_back(RW'(1));
            b_data.push_back(DW'(5 + k));
        end
        for (int k = 0; k < 3; k++) begin
            b_addr.push_back(RW'(0));
            b_data.push_back(DW'(1));
        end
        run_round(2, 3, 0);
        n_vec++;
        if (timeout || ow_addr.size() != 6) begin
            n_bad++;
            $display("FAIL fwd_count: got %0d writes (timeout %b) want 6", ow_addr.size(), timeout);
        end
        for (int k = 0; k < 3 && k < ow_addr.size(); k++) begin
            n_vec++;
            if (ow_addr[k] !== RW'(1) || ow_data[k] !== want[k]) begin
                n_bad++;
                $display("FAIL fwd_write%0d: got a%0d d%0d want a1 d%0d", k,
                         ow_addr[k], ow_data[k], want[k]);
            end
        end
    endtask

    task automatic test_addr_err;
        b_addr.delete();
        b_data.delete();
        b_addr.push_back(RW'(0)); b_data.push_back(DW'(3));
        b_addr.push_back(RW'(1)); b_data.push_back(DW'(4));
        b_addr.push_back(RW'(7)); b_data.push_back(DW'(9));
        b_addr.push_back(RW'(2)); b_data.push_back(DW'(5));
        build_expected(4);
        run_round(4, 1, 20);
        n_vec++;
        if (timeout || ow_addr.size() != e_addr.size() || n_reads != e_reads) begin
            n_bad++;
            $display("FAIL err_writes: got %0d writes %0d reads timeout %b want %0d writes %0d reads",
                     ow_addr.size(), n_reads, timeout, e_addr.size(), e_reads);
        end
        n_vec++;
        if (addr_err !== e_err) begin
            n_bad++;
            $display("FAIL err_flag: got %b want %b", addr_err, e_err);
        end
        n_vec++;
        if (fin_q.size() != 1 || fin_q[0] != last_acc + 1) begin
            n_bad++;
            $display("FAIL err_fin: got %0d pulses first at %0d want 1 at %0d",
                     fin_q.size(), (fin_q.size() > 0) ? fin_q[0] : -1, last_acc + 1);
        end
        b_addr.delete();
        b_data.delete();
        b_addr.push_back(RW'(0));
        b_data.push_back(DW'(5));
        run_round(1, 1, 0);
        n_vec++;
        if (err_after_start !== 1'b0 || addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got %b/%b want 0/0", err_after_start, addr_err);
        end
    endtask

    task automatic test_overflow;
        logic [DW-1:0] want;
`ifdef PART_SUM_SAT_EN
        want = 16'd32767;
`else
        want = 16'hEA60;
`endif
        b_addr.delete();
        b_data.delete();
        b_addr.push_back(RW'(0)); b_data.push_back(DW'(30000));
        b_addr.push_back(RW'(0)); b_data.push_back(DW'(30000));
        run_round(1, 2, 0);
        n_vec++;
        if (ow_data.size() != 2) begin
            n_bad++;
            $display("FAIL ovf_count: got %0d writes want 2", ow_data.size());
        end else if (ow_data[0] !== DW'(30000) || ow_data[1] !== want) begin
            n_bad++;
            $display("FAIL ovf_value: got %0d,%0d want 30000,%0d", ow_data[0], ow_data[1], want);
        end
    endtask

    task automatic test_zero_round;
        for (int z = 0; z < 2; z++) begin
            b_addr.delete();
            b_data.delete();
            run_round((z == 0) ? 5 : 0, (z == 0) ? 0 : 3, 0);
            n_vec++;
            if (ow_addr.size() != 0 || junk_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL zero%0d_quiet: got %0d writes rdy %b want 0 writes rdy 0",
                         z, ow_addr.size(), junk_rdy);
            end
            n_vec++;
            if (fin_q.size() != 1 || fin_q[0] != start_cyc + 1) begin
                n_bad++;
                $display("FAIL zero%0d_fin: got %0d pulses first at %0d want 1 at %0d", z,
                         fin_q.size(), (fin_q.size() > 0) ? fin_q[0] : -1, start_cyc + 1);
            end
        end
    endtask

    task automatic test_reset_mid_round;
        logic rdy_seen;
        logic rdy_after;
        rdy_after = 1'b0;
        @(negedge clk);
        start = 1'b1;
        rank_no = RW'(4);
        contrib_no = CW'(2);
        @(negedge clk);
        start = 1'b0;
        en = 1'b1;
        addr = RW'(2);
        data = DW'(9);
        #1 rdy_seen = recv_rdy;
        ow_addr.delete();
        ow_data.delete();
        fin_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            en = 1'b1;
            #1 if (recv_rdy) rdy_after = 1'b1;
            @(negedge clk);
        end
        en = 1'b0;
        n_vec++;
        if (rdy_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_accept: got rdy %b want 1", rdy_seen);
        end
        n_vec++;
        if (ow_addr.size() != 0 || fin_q.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: got %0d writes %0d fins want 0 and 0",
                     ow_addr.size(), fin_q.size());
        end
        n_vec++;
        if (rdy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_idle: got rdy %b want 0", rdy_after);
        end
    endtask

    task automatic test_back_to_back;
        b_addr.delete();
        b_data.delete();
        for (int k = 0; k < 16; k++) begin
            b_addr.push_back(RW'($urandom_range(1)));
            b_data.push_back(DW'($urandom_range(2000)));
        end
        build_expected(2);
        run_round(2, 8, 0);
        n_vec++;
        if (timeout || last_acc - first_acc != 15) begin
            n_bad++;
            $display("FAIL b2b_rate: got span %0d timeout %b want 15", last_acc - first_acc, timeout);
        end
        n_vec++;
        if (ow_addr.size() != e_addr.size()) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want %0d", ow_addr.size(), e_addr.size());
        end
        for (int k = 0; k < e_addr.size() && k < ow_addr.size(); k++) begin
            n_vec++;
            if ({ow_addr[k], ow_data[k]} !== {e_addr[k], e_data[k]}) begin
                n_bad++;
                $display("FAIL b2b_write%0d: got a%0d d%0d want a%0d d%0d", k,
                         ow_addr[k], ow_data[k], e_addr[k], e_data[k]);
            end
        end
    endtask

    task automatic test_random;
        int rank;
        int contrib;
        for (int r = 0; r < 6; r++) begin
            rank = (r == 5) ? 31 : int'($urandom_range(8, 1));
            contrib = int'($urandom_range(5, 1));
            b_addr.delete();
            b_data.delete();
            for (int k = 0; k < rank * contrib; k++) begin
                if ($urandom_range(9) == 0) b_addr.push_back(RW'($urandom));
                else b_addr.push_back(RW'($urandom_range(rank - 1)));
                b_data.push_back(DW'($urandom));
            end
            build_expected(rank);
            run_round(rank, contrib, int'($urandom_range(40)));
            n_vec++;
            if (timeout || ow_addr.size() != e_addr.size() || n_reads != e_reads) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d writes %0d reads timeout %b want %0d %0d", r,
                         ow_addr.size(), n_reads, timeout, e_addr.size(), e_reads);
            end
            for (int k = 0; k < e_addr.size() && k < ow_addr.size(); k++) begin
                n_vec++;
                if ({ow_addr[k], ow_data[k]} !== {e_addr[k], e_data[k]}) begin
                    n_bad++;
                    $display("FAIL rand%0d_write%0d: got a%0d d%0d want a%0d d%0d", r, k,
                             ow_addr[k], ow_data[k], e_addr[k], e_data[k]);
                end
            end
            n_vec++;
            if (addr_err !== e_err || fin_q.size() != 1 || fin_q[0] != last_acc + 1) begin
                n_bad++;
                $display("FAIL rand%0d_end: got err %b fins %0d at %0d want err %b 1 at %0d", r,
                         addr_err, fin_q.size(), (fin_q.size() > 0) ? fin_q[0] : -1,
                         e_err, last_acc + 1);
            end
        end
    endtask

    initial begin
        start = 1'b0;
        en = 1'b0;
        addr = '0;
        data = '0;
        rank_no = '0;
        contrib_no = '0;
        scramble = 1'b0;
        timeout = 1'b0;
        test_reset;
        test_basic_round;
        test_forwarding;
        test_addr_err;
        test_overflow;
        test_zero_round;
        test_reset_mid_round;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
